// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-side constants and types.
package rv32_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ILEN    = 32;
   localparam int unsigned PC_STEP = 4;

   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two depth FIFO of fetched {pc, instr} pairs with flush.
// Head entry and its valid flag are held in registers; flush keeps the last head value.
module fetch_queue
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output fetch_entry_t head_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   fetch_entry_t     out_q, out_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = ~valid_q;
   assign head_o  = out_q;

   assign do_pop  = pop_i & valid_q & ~flush_i;
   assign do_push = push_i & ~flush_i & (~full_o | do_pop);

   // Next-state pointers, count and registered head copy
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      out_d   = out_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + PTR_W'(1);
         if (do_pop)  head_d = head_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
         // New head is the entry being written when it lands on the head slot
         if (count_d != '0)
            out_d = (do_push && (tail_q == head_d)) ? push_data_i : mem_q[head_d];
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= push_data_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem address, fetch queue to decode, redirects.
// Optional misaligned-redirect trap with HALT state under FETCH_MISALIGN_TRAP_EN.
module fetch_unit
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = RESET_VECTOR,
   parameter int unsigned     QUEUE_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_a,
   input  logic [ILEN-1:0] imem_rd,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instr
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_fault
`endif
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            halted;
   logic            q_full, q_empty;
   logic            pop, push;
   fetch_entry_t    push_entry, head_entry;

   assign imem_a     = pc_q;
   assign out_valid  = ~q_empty;
   assign out_pc     = head_entry.pc;
   assign out_instr  = head_entry.instr;
   assign pop        = out_valid & out_ready;
   assign push       = ~redirect_valid & ~halted & (~q_full | pop);
   assign push_entry = '{pc: pc_q, instr: imem_rd};

`ifdef FETCH_MISALIGN_TRAP_EN
   fetch_state_t state_q;
   logic         fault_q;
   logic         misaligned;

   assign misaligned  = (redirect_pc[1:0] != 2'b00);
   assign halted      = (state_q == ST_HALT);
   assign fetch_fault = fault_q;

   // Only an aligned redirect (or reset) leaves HALT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN:
               if (redirect_valid && misaligned) begin
                  state_q <= ST_HALT;
                  fault_q <= 1'b1;
               end
            ST_HALT:
               if (redirect_valid && !misaligned) begin
                  state_q <= ST_RUN;
                  fault_q <= 1'b0;
               end
         endcase
      end
   end
`else
   assign halted = 1'b0;
`endif

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         pc_d = misaligned ? redirect_pc : (redirect_pc & ~XLEN'(3));
`else
         pc_d = redirect_pc & ~XLEN'(3);
`endif
      end else if (push) begin
         pc_d = pc_q + XLEN'(PC_STEP);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   fetch_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (redirect_valid),
      .push_i     (push),
      .push_data_i(push_entry),
      .pop_i      (pop),
      .full_o     (q_full),
      .empty_o    (q_empty),
      .head_o     (head_entry)
   );

endmodule
